subtrai_bcd: RTL and testbench



---
 rtl/subtrai_bcd_if.sv | 26 ++
 rtl/subtrai_bcd.sv | 150 +++++++++++++++
 tb/tb_subtrai_bcd.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/subtrai_bcd_if.sv
// Operand/result bundle between the calculator control logic and the BCD subtractor.
// The control side drives the start strobe and the operands; the subtractor returns result and status.
interface subtrai_bcd_if #(
    parameter int unsigned DIGITOS = 2
);
    localparam int unsigned W = 4 * DIGITOS;

    logic         agora;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] S;
    logic         negativo;
    logic         erro;
    logic         ocupado;
    logic         pronto;

    modport master (
        output agora, A, B,
        input  S, negativo, erro, ocupado, pronto
    );

    modport slave (
        input  agora, A, B,
        output S, negativo, erro, ocupado, pronto
    );
endinterface

// File: rtl/subtrai_bcd.sv
// Sequential packed-BCD subtractor, one digit per cycle, sign-magnitude result.
// Optional invalid-digit check enabled by defining SUBTRAI_ERRO_EN.
module subtrai_bcd #(
    parameter int unsigned DIGITOS = 2
) (
    input  logic            clk,
    input  logic            rst,
    subtrai_bcd_if.slave    bus
);
    localparam int unsigned W  = 4 * DIGITOS;
    localparam int unsigned IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

    typedef enum logic [1:0] {IDLE, SUB, COMP, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  r_q, r_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          borrow_q, borrow_d;
    logic [W-1:0]  s_q, s_d;
    logic          negativo_q, negativo_d;
    logic          erro_q, erro_d;
    logic          ocupado_q, ocupado_d;
    logic          pronto_q, pronto_d;

    logic [3:0]    op_x, op_y, digit;
    logic [4:0]    diff;
    logic          borrow_out;
    logic          last_digit;
    logic          bad_c;

`ifdef SUBTRAI_ERRO_EN
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(DIGITOS); i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_comb bad_c = has_bad_digit(bus.A) | has_bad_digit(bus.B);
`else
    always_comb bad_c = 1'b0;
`endif

    // Shared digit step: SUB uses a[i]-b[i], COMP uses 0-r[i], both with borrow in.
    always_comb begin
        op_x       = (state_q == SUB) ? a_q[4*int'(idx_q) +: 4] : 4'd0;
        op_y       = (state_q == SUB) ? b_q[4*int'(idx_q) +: 4] : r_q[4*int'(idx_q) +: 4];
        diff       = {1'b0, op_x} - {1'b0, op_y} - 5'(borrow_q);
        borrow_out = diff[4];
        digit      = borrow_out ? 4'(diff + 5'd10) : diff[3:0];
        last_digit = (idx_q == IW'(DIGITOS - 1));
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        idx_d      = idx_q;
        borrow_d   = borrow_q;
        s_d        = s_q;
        negativo_d = negativo_q;
        erro_d     = erro_q;
        pronto_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // ocupado_q still high marks the pronto cycle, during which starts are ignored.
                if (bus.agora && !ocupado_q) begin
                    a_d        = bus.A;
                    b_d        = bus.B;
                    r_d        = '0;
                    idx_d      = '0;
                    borrow_d   = 1'b0;
                    negativo_d = 1'b0;
                    erro_d     = bad_c;
                    state_d    = bad_c ? DONE : SUB;
                end
            end
            SUB: begin
                r_d[4*int'(idx_q) +: 4] = digit;
                borrow_d                = borrow_out;
                if (last_digit) begin
                    if (borrow_out) begin
                        state_d    = COMP;
                        negativo_d = 1'b1;
                        idx_d      = '0;
                        borrow_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            COMP: begin
                r_d[4*int'(idx_q) +: 4] = digit;
                borrow_d                = borrow_out;
                if (last_digit) state_d = DONE;
                else            idx_d   = idx_q + IW'(1);
            end
            DONE: begin
                s_d      = erro_q ? '0 : r_q;
                pronto_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ocupado_d = (state_d != IDLE) || pronto_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            idx_q      <= '0;
            borrow_q   <= 1'b0;
            s_q        <= '0;
            negativo_q <= 1'b0;
            erro_q     <= 1'b0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            r_q        <= r_d;
            idx_q      <= idx_d;
            borrow_q   <= borrow_d;
            s_q        <= s_d;
            negativo_q <= negativo_d;
            erro_q     <= erro_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
        end
    end

    assign bus.S        = s_q;
    assign bus.negativo = negativo_q;
    assign bus.erro     = erro_q;
    assign bus.ocupado  = ocupado_q;
    assign bus.pronto   = pronto_q;
endmodule

// File: tb/tb_subtrai_bcd.sv
// Directed and randomised bench for subtrai_bcd with DIGITOS=2; expected results go through a scoreboard queue.
module tb_subtrai_bcd;
    localparam int unsigned D = 2;
    localparam int unsigned W = 4 * D;

    typedef struct {
        logic [W-1:0] s;
        logic         neg;
        logic         err;
        int           lat;
        string        tag;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    subtrai_bcd_if #(.DIGITOS(D)) bus ();

    subtrai_bcd #(.DIGITOS(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(D); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Start one operation, track busy/latency, compare against the scoreboard head on pronto.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] es, input logic en, input logic ee,
                          input int lat, input bit repulse);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   seen;
        e.s = es; e.neg = en; e.err = ee; e.lat = lat; e.tag = tag;
        @(negedge clk);
        bus.agora = 1'b1;
        bus.A     = a;
        bus.B     = b;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.agora = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 40) begin
            check({tag, "_ocupado"}, 32'(bus.ocupado), 32'd1);
            if (bus.pronto === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (repulse && cyc == 1) begin
                bus.agora = 1'b1;
                bus.A     = 8'h99;
                bus.B     = 8'h01;
            end else begin
                bus.agora = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.agora = 1'b0;
        got = sb.pop_front();
        check({got.tag, "_pronto_seen"}, 32'(seen), 32'd1);
        check({got.tag, "_latency"}, 32'(cyc), 32'(got.lat));
        check({got.tag, "_S"}, 32'(bus.S), 32'(got.s));
        check({got.tag, "_negativo"}, 32'(bus.negativo), 32'(got.neg));
        check({got.tag, "_erro"}, 32'(bus.erro), 32'(got.err));
        @(posedge clk); #1;
        check({got.tag, "_pronto_1cyc"}, 32'(bus.pronto), 32'd0);
        check({got.tag, "_idle_ocupado"}, 32'(bus.ocupado), 32'd0);
        check({got.tag, "_S_hold"}, 32'(bus.S), 32'(got.s));
    endtask

    initial begin
        int ai, bi, diff;
        logic [W-1:0] ra, rb;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.agora = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_S", 32'(bus.S), 32'd0);
        check("reset_negativo", 32'(bus.negativo), 32'd0);
        check("reset_erro", 32'(bus.erro), 32'd0);
        check("reset_ocupado", 32'(bus.ocupado), 32'd0);
        check("reset_pronto", 32'(bus.pronto), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("pos_47_12", 8'h47, 8'h12, 8'h35, 1'b0, 1'b0, 3, 1'b0);
        run_op("neg_12_47", 8'h12, 8'h47, 8'h35, 1'b1, 1'b0, 5, 1'b0);
        run_op("neg_00_99", 8'h00, 8'h99, 8'h99, 1'b1, 1'b0, 5, 1'b0);
        run_op("zero_50_50", 8'h50, 8'h50, 8'h00, 1'b0, 1'b0, 3, 1'b0);
        run_op("borrow_30_01", 8'h30, 8'h01, 8'h29, 1'b0, 1'b0, 3, 1'b0);
        run_op("neg_98_99", 8'h98, 8'h99, 8'h01, 1'b1, 1'b0, 5, 1'b0);
        run_op("repulse_47_12", 8'h47, 8'h12, 8'h35, 1'b0, 1'b0, 3, 1'b1);
`ifdef SUBTRAI_ERRO_EN
        run_op("erro_1a_05", 8'h1A, 8'h05, 8'h00, 1'b0, 1'b1, 1, 1'b0);
        run_op("erro_clear", 8'h47, 8'h12, 8'h35, 1'b0, 1'b0, 3, 1'b0);
`endif

        // Abort in the middle of COMP: after edge 3 a negative op is on its second COMP digit.
        @(negedge clk);
        bus.agora = 1'b1;
        bus.A     = 8'h12;
        bus.B     = 8'h47;
        @(posedge clk); #1;
        bus.agora = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("midcomp_ocupado", 32'(bus.ocupado), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_S", 32'(bus.S), 32'd0);
        check("rst_negativo", 32'(bus.negativo), 32'd0);
        check("rst_erro", 32'(bus.erro), 32'd0);
        check("rst_ocupado", 32'(bus.ocupado), 32'd0);
        check("rst_pronto", 32'(bus.pronto), 32'd0);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_rst_no_pronto", 32'(bus.pronto), 32'd0);
        end
        run_op("after_rst_47_12", 8'h47, 8'h12, 8'h35, 1'b0, 1'b0, 3, 1'b0);

        for (int k = 0; k < 8; k++) begin
            ra   = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            rb   = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            ai   = bcd2int(ra);
            bi   = bcd2int(rb);
            diff = ai - bi;
            if (diff < 0) run_op("rand", ra, rb, int2bcd(-diff), 1'b1, 1'b0, 2 * D + 1, 1'b0);
            else          run_op("rand", ra, rb, int2bcd(diff), 1'b0, 1'b0, D + 1, 1'b0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
